// File: rtl/yapay_zeka_komut_birimi.sv
// yapay_zeka_komut_birimi
// Decodes custom-opcode AI-accelerator instructions and turns them into
// filter/data load and clear pulses plus a convolution run handshake.
// The handshake stalls the pipeline until the accelerator reports a result
// or the wait limit expires. The result is then presented for writeback
// for one cycle.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   durdur_i                     pipeline freeze (holds all state, masks pulses)
//   buyruk_gecerli_i, buyruk_i   instruction valid / instruction word
//   rs1_veri_i, rs2_veri_i       operand values of the instruction
//   conv_sonuc_i, conv_hazir_i   accelerator result / result ready
//   blok_aktif_o                 accelerator selected this cycle
//   rs1_veri_o, rs2_veri_o       operands registered for the accelerator
//   filtre_rs1_en_o/rs2_en_o     filter load enables, filtre_sil_o filter clear
//   veri_rs1_en_o/rs2_en_o       data load enables, veri_sil_o data clear
//   conv_yap_en_o                convolution run request
//   stall_o                      hold pipeline
//   sonuc_o, rd_o                writeback value / register
//   sonuc_gecerli_o              writeback valid pulse
//   gecersiz_o                   illegal funct3 pulse
//   tasma_o                      sticky: a load was dropped on overflow
//   zaman_asimi_o                sticky: accelerator wait timed out
module yapay_zeka_komut_birimi #(
  parameter int         ZAMAN_ASIMI = 40,
  parameter logic [6:0] OPCODE      = 7'b0001011
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        durdur_i,
  input  logic        buyruk_gecerli_i,
  input  logic [31:0] buyruk_i,
  input  logic [31:0] rs1_veri_i,
  input  logic [31:0] rs2_veri_i,
  input  logic [31:0] conv_sonuc_i,
  input  logic        conv_hazir_i,
  output logic        blok_aktif_o,
  output logic [31:0] rs1_veri_o,
  output logic [31:0] rs2_veri_o,
  output logic        filtre_rs1_en_o,
  output logic        filtre_rs2_en_o,
  output logic        filtre_sil_o,
  output logic        veri_rs1_en_o,
  output logic        veri_rs2_en_o,
  output logic        veri_sil_o,
  output logic        conv_yap_en_o,
  output logic        stall_o,
  output logic [31:0] sonuc_o,
  output logic [4:0]  rd_o,
  output logic        sonuc_gecerli_o,
  output logic        gecersiz_o,
  output logic        tasma_o,
  output logic        zaman_asimi_o
);

  localparam int TW = (ZAMAN_ASIMI < 2) ? 1 : $clog2(ZAMAN_ASIMI);
  localparam logic [TW-1:0] SAYAC_SON = TW'(ZAMAN_ASIMI - 1);
  localparam logic [4:0]    ELEMAN_MAX = 5'd16;

  localparam logic [1:0] BOSTA = 2'd0;
  localparam logic [1:0] BEKLE = 2'd1;
  localparam logic [1:0] SONUC = 2'd2;

  logic [1:0]    durum;
  logic [TW-1:0] bekle_sayac;
  logic [4:0]    filtre_sayac;
  logic [4:0]    veri_sayac;
  logic [4:0]    rd_q;

  // Commands issued last cycle; they stay armed across a freeze.
  logic bek_f1, bek_f2, bek_fs, bek_v1, bek_v2, bek_vs, bek_gec;

  logic       kabul;
  logic [2:0] funct3;
  logic       cift;
  logic [4:0] artis;
  logic       f_yukle, v_yukle, f_sil, v_sil, conv_kabul, gecersiz_kabul;
  logic       f_ok, v_ok;

  logic unused_buyruk_bitleri;
  assign unused_buyruk_bitleri = ^{buyruk_i[31:26], buyruk_i[24:15]};

  assign funct3 = buyruk_i[14:12];
  assign cift   = buyruk_i[25];
  assign artis  = cift ? 5'd2 : 5'd1;

  // Acceptance uses only the FSM busy condition, not stall_o itself, so the
  // combinational stall for a fresh conv run does not block its own accept.
  always_comb begin
    kabul          = buyruk_gecerli_i & ~durdur_i & ~rst_i &
                     (buyruk_i[6:0] == OPCODE) & (durum != BEKLE);
    f_yukle        = kabul & (funct3 == 3'b000);
    v_yukle        = kabul & (funct3 == 3'b001);
    f_sil          = kabul & (funct3 == 3'b010);
    v_sil          = kabul & (funct3 == 3'b011);
    conv_kabul     = kabul & (funct3 == 3'b100);
    gecersiz_kabul = kabul & funct3[2] & (funct3[1:0] != 2'b00);
    f_ok           = f_yukle & ((filtre_sayac + artis) <= ELEMAN_MAX);
    v_ok           = v_yukle & ((veri_sayac + artis) <= ELEMAN_MAX);
  end

  // Command pulses, element counters, overflow flag and operand registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bek_f1       <= 1'b0;
      bek_f2       <= 1'b0;
      bek_fs       <= 1'b0;
      bek_v1       <= 1'b0;
      bek_v2       <= 1'b0;
      bek_vs       <= 1'b0;
      bek_gec      <= 1'b0;
      filtre_sayac <= '0;
      veri_sayac   <= '0;
      tasma_o      <= 1'b0;
      rs1_veri_o   <= '0;
      rs2_veri_o   <= '0;
    end else begin
      if (!durdur_i) begin
        bek_f1  <= f_ok & ~cift;
        bek_f2  <= f_ok & cift;
        bek_fs  <= f_sil;
        bek_v1  <= v_ok & ~cift;
        bek_v2  <= v_ok & cift;
        bek_vs  <= v_sil;
        bek_gec <= gecersiz_kabul;
      end
      if (f_sil) begin
        filtre_sayac <= '0;
      end else if (f_ok) begin
        filtre_sayac <= filtre_sayac + artis;
      end
      if (v_sil) begin
        veri_sayac <= '0;
      end else if (v_ok) begin
        veri_sayac <= veri_sayac + artis;
      end
      if (f_sil | v_sil) begin
        tasma_o <= 1'b0;
      end else if ((f_yukle & ~f_ok) | (v_yukle & ~v_ok)) begin
        tasma_o <= 1'b1;
      end
      if (f_ok | v_ok) begin
        rs1_veri_o <= rs1_veri_i;
        rs2_veri_o <= rs2_veri_i;
      end
    end
  end

  // Convolution handshake. A conv run may also start straight from SONUC,
  // since stall_o is low there and the pipeline can issue again.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum         <= BOSTA;
      bekle_sayac   <= '0;
      rd_q          <= '0;
      sonuc_o       <= '0;
      zaman_asimi_o <= 1'b0;
    end else if (!durdur_i) begin
      case (durum)
        BEKLE: begin
          if (conv_hazir_i) begin
            sonuc_o <= conv_sonuc_i;
            durum   <= SONUC;
          end else if (bekle_sayac == SAYAC_SON) begin
            sonuc_o       <= conv_sonuc_i;
            zaman_asimi_o <= 1'b1;
            durum         <= SONUC;
          end else begin
            bekle_sayac <= bekle_sayac + TW'(1);
          end
        end
        default: begin
          if (conv_kabul) begin
            durum       <= BEKLE;
            bekle_sayac <= '0;
            rd_q        <= buyruk_i[11:7];
          end else begin
            durum <= BOSTA;
          end
        end
      endcase
    end
  end

  // Armed pulses are masked while frozen and released once durdur_i drops.
  always_comb begin
    filtre_rs1_en_o = bek_f1 & ~durdur_i;
    filtre_rs2_en_o = bek_f2 & ~durdur_i;
    filtre_sil_o    = bek_fs & ~durdur_i;
    veri_rs1_en_o   = bek_v1 & ~durdur_i;
    veri_rs2_en_o   = bek_v2 & ~durdur_i;
    veri_sil_o      = bek_vs & ~durdur_i;
    gecersiz_o      = bek_gec & ~durdur_i;
    conv_yap_en_o   = (durum == BEKLE);
    stall_o         = (durum == BEKLE) | conv_kabul;
    sonuc_gecerli_o = (durum == SONUC) & ~durdur_i;
    rd_o            = sonuc_gecerli_o ? rd_q : 5'd0;
    blok_aktif_o    = filtre_rs1_en_o | filtre_rs2_en_o | filtre_sil_o |
                      veri_rs1_en_o | veri_rs2_en_o | veri_sil_o | conv_yap_en_o;
  end

endmodule

// File: tb/tb_yapay_zeka_komut_birimi.sv
// Testbench for yapay_zeka_komut_birimi: directed scenarios followed by
// random instruction streams, all compared cycle by cycle against a
// transaction-level reference model (queue of issued commands, counters,
// and a wait/result phase for the convolution handshake).
module tb_yapay_zeka_komut_birimi;

  localparam int         ZA = 40;
  localparam logic [6:0] OP = 7'b0001011;

  logic        clk = 1'b0;
  logic        rst, durdur, buyruk_gecerli, conv_hazir;
  logic [31:0] buyruk, rs1_veri, rs2_veri, conv_sonuc;
  logic        blok_aktif, filtre_rs1_en, filtre_rs2_en, filtre_sil;
  logic        veri_rs1_en, veri_rs2_en, veri_sil, conv_yap_en, stall;
  logic [31:0] rs1_out, rs2_out, sonuc;
  logic [4:0]  rd;
  logic        sonuc_gecerli, gecersiz, tasma, zaman_asimi;

  always #5 clk = ~clk;

  yapay_zeka_komut_birimi #(.ZAMAN_ASIMI(ZA), .OPCODE(OP)) dut (
    .clk_i(clk), .rst_i(rst), .durdur_i(durdur),
    .buyruk_gecerli_i(buyruk_gecerli), .buyruk_i(buyruk),
    .rs1_veri_i(rs1_veri), .rs2_veri_i(rs2_veri),
    .conv_sonuc_i(conv_sonuc), .conv_hazir_i(conv_hazir),
    .blok_aktif_o(blok_aktif), .rs1_veri_o(rs1_out), .rs2_veri_o(rs2_out),
    .filtre_rs1_en_o(filtre_rs1_en), .filtre_rs2_en_o(filtre_rs2_en),
    .filtre_sil_o(filtre_sil), .veri_rs1_en_o(veri_rs1_en),
    .veri_rs2_en_o(veri_rs2_en), .veri_sil_o(veri_sil),
    .conv_yap_en_o(conv_yap_en), .stall_o(stall), .sonuc_o(sonuc), .rd_o(rd),
    .sonuc_gecerli_o(sonuc_gecerli), .gecersiz_o(gecersiz),
    .tasma_o(tasma), .zaman_asimi_o(zaman_asimi)
  );

  int total = 0;
  int bad   = 0;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model. Command kinds: 1 filter rs1, 2 filter rs2, 3 filter clear,
  // 4 data rs1, 5 data rs2, 6 data clear, 7 illegal.
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  cmd_t        pend_q[$];
  int          f_count, v_count, waited;
  int          phase;
  bit          m_tasma, m_zaman;
  logic [31:0] m_sonuc;
  logic [4:0]  m_rd;

  localparam int IDLE = 0, WAITING = 1, RESULT = 2;

  task automatic modelReset();
    pend_q.delete();
    f_count = 0;
    v_count = 0;
    waited  = 0;
    phase   = IDLE;
    m_tasma = 0;
    m_zaman = 0;
    m_sonuc = '0;
    m_rd    = '0;
  endtask

  function automatic logic [31:0] mkInstr(input int f3, input bit c, input logic [4:0] r, input logic [6:0] op);
    logic [9:0] junk;
    junk = 10'($urandom);
    return {6'b0, c, junk, 3'(f3), r, op};
  endfunction

  // One clock cycle: drive at the falling edge, compare settled outputs
  // against the model, then advance the model to what the next rising edge does.
  task automatic applyStimulus(input bit v, input logic [31:0] ins, input logic [31:0] a,
                               input logic [31:0] b, input bit frz, input bit rdy,
                               input logic [31:0] res, input bit rs);
    bit   accept, now_pulse, sg;
    int   f3, k, inc, cnt;
    bit   c;
    cmd_t head, nc;
    @(negedge clk);
    rst = rs; buyruk_gecerli = v; buyruk = ins; rs1_veri = a; rs2_veri = b;
    durdur = frz; conv_hazir = rdy; conv_sonuc = res;
    #1;
    if (rs) begin
      modelReset();
    end else begin
      f3        = int'(ins[14:12]);
      c         = ins[25];
      accept    = v && !frz && (ins[6:0] == OP) && (phase != WAITING);
      now_pulse = (pend_q.size() > 0) && !frz;
      k = 0;
      if (now_pulse) begin
        head = pend_q[0];
        k    = head.kind;
      end
      sg = (phase == RESULT) && !frz;
      checkOutput("stall", stall, (phase == WAITING) || (accept && f3 == 4));
      checkOutput("conv_yap_en", conv_yap_en, phase == WAITING);
      checkOutput("filtre_rs1_en", filtre_rs1_en, k == 1);
      checkOutput("filtre_rs2_en", filtre_rs2_en, k == 2);
      checkOutput("filtre_sil", filtre_sil, k == 3);
      checkOutput("veri_rs1_en", veri_rs1_en, k == 4);
      checkOutput("veri_rs2_en", veri_rs2_en, k == 5);
      checkOutput("veri_sil", veri_sil, k == 6);
      checkOutput("gecersiz", gecersiz, k == 7);
      checkOutput("blok_aktif", blok_aktif, (k >= 1 && k <= 6) || phase == WAITING);
      if (k == 1 || k == 2 || k == 4 || k == 5) begin
        checkOutput("rs1_veri", rs1_out, head.a);
        checkOutput("rs2_veri", rs2_out, head.b);
      end
      checkOutput("sonuc_gecerli", sonuc_gecerli, sg);
      checkOutput("rd", rd, sg ? m_rd : 5'd0);
      checkOutput("sonuc", sonuc, m_sonuc);
      checkOutput("tasma", tasma, m_tasma);
      checkOutput("zaman_asimi", zaman_asimi, m_zaman);

      if (!frz) begin
        if (now_pulse) void'(pend_q.pop_front());
        if (phase == WAITING) begin
          if (rdy) begin
            m_sonuc = res;
            phase   = RESULT;
          end else begin
            waited++;
            if (waited == ZA) begin
              m_sonuc = res;
              m_zaman = 1;
              phase   = RESULT;
            end
          end
        end else if (accept && f3 == 4) begin
          phase  = WAITING;
          waited = 0;
          m_rd   = ins[11:7];
        end else begin
          phase = IDLE;
        end
        if (accept) begin
          nc.a = a;
          nc.b = b;
          nc.kind = 0;
          if (f3 == 0 || f3 == 1) begin
            inc = c ? 2 : 1;
            cnt = (f3 == 0) ? f_count : v_count;
            if (cnt + inc > 16) begin
              m_tasma = 1;
            end else begin
              if (f3 == 0) f_count += inc; else v_count += inc;
              nc.kind = (f3 == 0) ? (c ? 2 : 1) : (c ? 5 : 4);
            end
          end else if (f3 == 2) begin
            f_count = 0; m_tasma = 0; nc.kind = 3;
          end else if (f3 == 3) begin
            v_count = 0; m_tasma = 0; nc.kind = 6;
          end else if (f3 >= 5) begin
            nc.kind = 7;
          end
          if (nc.kind != 0) pend_q.push_back(nc);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, '0, 0, 0, '0, 0);
  endtask

  int  cnt_a, cnt_b;
  bit  seen;

  initial begin
    modelReset();
    rst = 1; durdur = 0; buyruk_gecerli = 0; buyruk = '0; rs1_veri = '0;
    rs2_veri = '0; conv_hazir = 0; conv_sonuc = '0;

    // Reset with a conv run offered: it must be ignored.
    applyStimulus(1, mkInstr(4, 0, 5'd3, OP), 32'h1, 32'h2, 0, 0, '0, 1);
    applyStimulus(1, mkInstr(4, 0, 5'd3, OP), 32'h1, 32'h2, 0, 0, '0, 1);
    idle(1);
    checkOutput("reset_rs1", rs1_out, 32'h0);
    checkOutput("reset_rs2", rs2_out, 32'h0);
    checkOutput("reset_sonuc", sonuc, 32'h0);

    // Filter load, cift=1.
    applyStimulus(1, mkInstr(0, 1, 5'd0, OP), 32'h5, 32'h7, 0, 0, '0, 0);
    idle(1);
    checkOutput("f_load_en2", filtre_rs2_en, 1'b1);
    checkOutput("f_load_rs1", rs1_out, 32'h5);
    checkOutput("f_load_rs2", rs2_out, 32'h7);
    checkOutput("f_load_stall", stall, 1'b0);

    // Nine back-to-back double data loads: the ninth overflows.
    applyStimulus(0, '0, '0, '0, 0, 0, '0, 1);
    cnt_a = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, mkInstr(1, 1, 5'd0, OP), $urandom, $urandom, 0, 0, '0, 0);
      if (veri_rs2_en) cnt_a++;
    end
    idle(1);
    if (veri_rs2_en) cnt_a++;
    checkOutput("v_load_pulses", cnt_a, 8);
    checkOutput("v_overflow", tasma, 1'b1);
    applyStimulus(1, mkInstr(3, 0, 5'd0, OP), '0, '0, 0, 0, '0, 0);
    idle(1);
    checkOutput("v_clear_pulse", veri_sil, 1'b1);
    checkOutput("v_clear_tasma", tasma, 1'b0);

    // Conv run, rd=10, result after 5 plain wait cycles.
    cnt_a = 0;
    applyStimulus(1, mkInstr(4, 0, 5'd10, OP), '0, '0, 0, 0, '0, 0);
    if (stall) cnt_a++;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, '0, '0, '0, 0, 0, $urandom, 0);
      if (stall) cnt_a++;
    end
    applyStimulus(0, '0, '0, '0, 0, 1, 32'h64, 0);
    if (stall) cnt_a++;
    idle(1);
    if (stall) cnt_a++;
    checkOutput("conv_stall_cycles", cnt_a, 7);
    checkOutput("conv_valid", sonuc_gecerli, 1'b1);
    checkOutput("conv_result", sonuc, 32'h64);
    checkOutput("conv_rd", rd, 5'd10);

    // Conv run that never gets a ready: timeout after ZA wait cycles.
    applyStimulus(1, mkInstr(4, 0, 5'd7, OP), '0, '0, 0, 0, '0, 0);
    cnt_b = 0;
    seen  = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      applyStimulus(0, '0, '0, '0, 0, 0, 32'hABCD0000 + i, 0);
      if (sonuc_gecerli) seen = 1;
      else if (conv_yap_en) cnt_b++;
    end
    checkOutput("timeout_reached", seen, 1'b1);
    checkOutput("timeout_cycles", cnt_b, ZA);
    checkOutput("timeout_flag", zaman_asimi, 1'b1);

    // Load accepted, then a three-cycle freeze.
    applyStimulus(1, mkInstr(1, 0, 5'd0, OP), 32'h11, 32'h22, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, '0, '0, 1, 0, '0, 0);
    idle(1);
    checkOutput("freeze_release_pulse", veri_rs1_en, 1'b1);

    // Reset in the middle of a wait abandons the conv run.
    applyStimulus(1, mkInstr(4, 0, 5'd9, OP), '0, '0, 0, 0, '0, 0);
    idle(3);
    applyStimulus(0, '0, '0, '0, 0, 1, 32'h55, 1);
    idle(1);
    checkOutput("midwait_reset_conv", conv_yap_en, 1'b0);
    checkOutput("midwait_reset_valid", sonuc_gecerli, 1'b0);
    checkOutput("midwait_reset_stall", stall, 1'b0);

    // Random instruction stream.
    for (int i = 0; i < 4000; i++) begin
      int          r, f3;
      bit          v, frz, rdy, rs;
      logic [6:0]  op;
      r = $urandom_range(0, 99);
      if (r < 40)      f3 = $urandom_range(0, 1);
      else if (r < 55) f3 = $urandom_range(2, 3);
      else if (r < 68) f3 = 4;
      else             f3 = $urandom_range(5, 7);
      op  = ($urandom_range(0, 99) < 8) ? (OP ^ 7'(1 << $urandom_range(0, 6))) : OP;
      v   = ($urandom_range(0, 99) < 70);
      frz = ($urandom_range(0, 99) < 15);
      rdy = ($urandom_range(0, 99) < 10);
      rs  = ($urandom_range(0, 999) < 5);
      applyStimulus(v, mkInstr(f3, 1'($urandom_range(0, 1)), 5'($urandom), op),
                    $urandom, $urandom, frz, rdy, $urandom, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/yapay_zeka_komut_birimi.md
YAPAY_ZEKA_KOMUT_BIRIMI -- requirements
Module: yapay_zeka_komut_birimi

Interface
REQ-001 SHALL have parameter ZAMAN_ASIMI, default 40, meaning max cycles BEKLE waits for conv_hazir_i.
REQ-002 SHALL have parameter OPCODE, default 7'b0001011, meaning custom opcode of AI-accelerator instructions.
REQ-003 SHALL have ports, one clock, synchronous active-high reset:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous reset, active-high
- durdur_i  in  1  pipeline freeze
- buyruk_gecerli_i  in  1  instruction valid
- buyruk_i  in  32  instruction word
- rs1_veri_i / rs2_veri_i  in  32 each  operand values
- conv_sonuc_i  in  32  accelerator result
- conv_hazir_i  in  1  accelerator result ready
- blok_aktif_o  out  1  accelerator selected
- rs1_veri_o / rs2_veri_o  out  32 each  registered operands to accelerator
- filtre_rs1_en_o, filtre_rs2_en_o, filtre_sil_o  out  1 each  filter commands
- veri_rs1_en_o, veri_rs2_en_o, veri_sil_o  out  1 each  data commands
- conv_yap_en_o  out  1  convolution run request
- stall_o  out  1  hold pipeline
- sonuc_o  out  32  writeback value
- rd_o  out  5  writeback register
- sonuc_gecerli_o  out  1  writeback valid pulse
- gecersiz_o  out  1  illegal-encoding pulse
- tasma_o  out  1  sticky load overflow
- zaman_asimi_o  out  1  sticky timeout

Function
REQ-004 SHALL decode only when buyruk_i[6:0]==OPCODE; funct3=buyruk_i[14:12], cift=buyruk_i[25].
REQ-005 SHALL map funct3: 000 filter load, 001 data load, 010 filter clear, 011 data clear, 100 conv run; 101-111 illegal.
REQ-006 SHALL accept an instruction in a cycle with buyruk_gecerli_i=1, durdur_i=0, stall_o=0.
REQ-007 SHALL, for an accepted load in cycle N, drive exactly one of *_rs1_en_o (cift=0) or *_rs2_en_o (cift=1) high for cycle N+1 only; rs1_veri_o/rs2_veri_o carry cycle-N operands in N+1; clear maps to a one-cycle *_sil_o pulse in N+1.
REQ-008 SHALL keep per-matrix element counters 0..16: +1 (cift=0), +2 (cift=1), reset to 0 on the matching clear.
REQ-009 SHALL drop a load that would push its counter past 16 (no enable pulse, counter unchanged) and set tasma_o; tasma_o clears only on any clear or reset.
REQ-010 SHALL sustain back-to-back loads/clears every cycle with stall_o=0.
REQ-011 SHALL pulse gecersiz_o in N+1 for an accepted illegal funct3 and issue nothing else.
REQ-012 SHALL use FSM BOSTA -> BEKLE -> SONUC -> BOSTA for conv run; loads/clears never leave BOSTA.
REQ-013 SHALL, on an accepted conv run in cycle N: assert stall_o combinationally in N, latch rd=buyruk_i[11:7], enter BEKLE in N+1.
REQ-014 SHALL hold conv_yap_en_o=1 and stall_o=1 throughout BEKLE.
REQ-015 SHALL, in BEKLE with conv_hazir_i=1, latch conv_sonuc_i into sonuc_o and enter SONUC next cycle.
REQ-016 SHALL count BEKLE cycles (durdur_i=0 only); at ZAMAN_ASIMI without conv_hazir_i latch conv_sonuc_i, set zaman_asimi_o (sticky until reset), enter SONUC.
REQ-017 SHALL in SONUC drive sonuc_gecerli_o=1, rd_o valid, stall_o=0, conv_yap_en_o=0 for exactly one cycle, then BOSTA.
REQ-018 SHALL hold FSM state, counters and timeout counter while durdur_i=1, force all command pulses and sonuc_gecerli_o to 0, and emit a blocked command pulse or SONUC pulse in the first cycle after durdur_i falls.
REQ-019 SHALL drive blok_aktif_o=1 in any cycle a command pulse or conv_yap_en_o is high.
REQ-020 SHALL keep sonuc_o stable from latch until next conv latch; rd_o=0 outside SONUC.

Reset
REQ-021 SHALL, with rst_i=1 at a rising edge, force FSM BOSTA, counters 0, sonuc_o 0, all 1-bit outputs 0, rs*_veri_o 0, regardless of operation in progress (mid-BEKLE reset abandons conv, no sonuc_gecerli_o).
REQ-022 SHALL ignore buyruk_gecerli_i during reset cycles.

Verification
REQ-023 Filter load cift=1 rs1=0x5, rs2=0x7 -> next cycle filtre_rs2_en_o=1, rs1_veri_o=0x5, rs2_veri_o=0x7, counter 2, stall_o=0.
REQ-024 Nine cift=1 data loads -> eighth ends counter 16, ninth gives no pulse, tasma_o=1; veri clear -> veri_sil_o pulse, tasma_o=0.
REQ-025 Conv run rd=10, conv_hazir_i after 5 cycles with 0x64 -> stall_o high 7 cycles, sonuc_gecerli_o=1, sonuc_o=0x64, rd_o=10.
REQ-026 Conv run, conv_hazir_i never high, ZAMAN_ASIMI=40 -> SONUC after 40 BEKLE cycles, zaman_asimi_o=1.
REQ-027 Load accepted then durdur_i=1 for 3 cycles -> enable pulse appears in first cycle after durdur_i falls; rst_i mid-BEKLE -> all outputs 0 next cycle.
